// File: rtl/pipelined_data_memory_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed LATENCY, byte/half/word lanes.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses return RespErr=1 instead of being realigned.
module pipelined_data_memory_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, signed_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                accept, enter_resp;

    logic [31:0]         mem [2**ADDR_W];

    logic                cur_wr, cur_signed;
    logic [1:0]          cur_size;
    logic [ADDR_W+1:0]   cur_addr, eff_addr;
    logic [31:0]         cur_wdata;
    logic [ADDR_W-1:0]   idx;
    logic [1:0]          lane;
    logic [31:0]         old_word, new_word, load_data;
    logic [15:0]         half_val;
    logic [7:0]          byte_val;
    logic                trap_err, do_write;
    logic                unused_addr;

    assign unused_addr = ^ReqAddr[31:ADDR_W+2];

    assign accept   = ReqValid && (state_q == StIdle);
    assign ReqReady = (state_q == StIdle);
    assign RespValid = (state_q == StResp);
    assign RespRData = rdata_q;
    assign RespErr   = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge, before anything is latched.
    assign cur_wr     = (state_q == StIdle) ? ReqWrite                 : wr_q;
    assign cur_size   = (state_q == StIdle) ? ReqSize                  : size_q;
    assign cur_signed = (state_q == StIdle) ? ReqSigned                : signed_q;
    assign cur_addr   = (state_q == StIdle) ? ReqAddr[ADDR_W+1:0]      : addr_q;
    assign cur_wdata  = (state_q == StIdle) ? ReqWData                 : wdata_q;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        unique case (cur_size)
            2'b01:   trap_err = cur_addr[0];
            2'b10:   trap_err = 1'b0;
            default: trap_err = (cur_addr[1:0] != 2'b00);
        endcase
    end
    assign eff_addr = cur_addr;
`else
    assign trap_err = 1'b0;
    always_comb begin
        unique case (cur_size)
            2'b01:   eff_addr = {cur_addr[ADDR_W+1:1], 1'b0};
            2'b10:   eff_addr = cur_addr;
            default: eff_addr = {cur_addr[ADDR_W+1:2], 2'b00};
        endcase
    end
`endif

    assign idx      = eff_addr[ADDR_W+1:2];
    assign lane     = eff_addr[1:0];
    assign old_word = mem[idx];
    assign half_val = lane[1] ? old_word[31:16] : old_word[15:0];
    assign byte_val = old_word[{lane, 3'b000} +: 8];

    always_comb begin
        unique case (cur_size)
            2'b01:   load_data = {{16{cur_signed & half_val[15]}}, half_val};
            2'b10:   load_data = {{24{cur_signed & byte_val[7]}}, byte_val};
            default: load_data = old_word;
        endcase
    end

    // Unaddressed lanes keep their old contents.
    always_comb begin
        new_word = old_word;
        unique case (cur_size)
            2'b01: begin
                if (lane[1]) new_word[31:16] = cur_wdata[15:0];
                else         new_word[15:0]  = cur_wdata[15:0];
            end
            2'b10:   new_word[{lane, 3'b000} +: 8] = cur_wdata[7:0];
            default: new_word = cur_wdata;
        endcase
    end

    assign do_write = enter_resp && cur_wr && !trap_err;
    assign rdata_d  = (cur_wr || trap_err) ? 32'h0 : load_data;
    assign err_d    = trap_err;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q     <= ReqWrite;
                size_q   <= ReqSize;
                signed_q <= ReqSigned;
                addr_q   <= ReqAddr[ADDR_W+1:0];
                wdata_q  <= ReqWData;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Array is not reset; a reset before the RESP edge means do_write never fires.
    always_ff @(posedge Clk) begin
        if (do_write) mem[idx] <= new_word;
    end

endmodule

// File: tb/tb_pipelined_data_memory_responder.sv
// Scoreboard bench for pipelined_data_memory_responder: directed requests, decoupled response monitor.
module tb_pipelined_data_memory_responder;

    localparam int unsigned AW  = 10;
    localparam int unsigned LAT = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [31:0] ReqAddr = 32'h0;
    logic [31:0] ReqWData = 32'h0;
    logic        RespValid;
    logic [31:0] RespRData;
    logic        RespErr;

    pipelined_data_memory_responder #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqSize   (ReqSize),
        .ReqSigned (ReqSigned),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .RespValid (RespValid),
        .RespRData (RespRData),
        .RespErr   (RespErr)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_acc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response per RespValid cycle.
    resp_t exp_r;
    always @(negedge Clk) begin
        if (Reset && RespValid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(sb.size()), 32'd1);
            end else begin
                exp_r = sb.pop_front();
                check("resp_rdata", RespRData, exp_r.rdata);
                check("resp_err", 32'(RespErr), 32'(exp_r.err));
            end
        end
    end

    // mode: 0 single, 1 first of burst, 2 middle of burst, 3 last of burst
    task automatic issue(input string name, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input bit exp_e, input int mode);
        int n = 0;
        @(negedge Clk);
        ReqValid  = 1'b1;
        ReqWrite  = wr;
        ReqSize   = sz;
        ReqSigned = sg;
        ReqAddr   = a;
        ReqWData  = wd;
        while (!ReqReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check({name, " ready"}, 32'(ReqReady), 32'd1);
        check({name, " idle_no_resp"}, 32'(RespValid), 32'd0);
        if (mode >= 2) check({name, " spacing"}, 32'(cyc - last_acc), 32'(LAT + 1));
        last_acc = cyc;
        sb.push_back('{rdata: exp_d, err: exp_e});
        @(posedge Clk);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge Clk);
            if (k == 1 && (mode == 0 || mode == 3)) ReqValid = 1'b0;
            check({name, " busy"}, 32'(ReqReady), 32'd0);
            check({name, " resp_timing"}, 32'(RespValid), (k == LAT) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int n;
        #12;
        check("reset_valid", 32'(RespValid), 32'd0);
        check("reset_rdata", RespRData, 32'd0);
        check("reset_err", 32'(RespErr), 32'd0);
        check("reset_ready", 32'(ReqReady), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;

        issue("st_word", 1, 2'b00, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 0);
        issue("ld_word", 0, 2'b00, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0);

        issue("st_zero", 1, 2'b00, 0, 32'h80, 32'h0, 32'h0, 0, 0);
        issue("st_byte", 1, 2'b10, 0, 32'h81, 32'hFFFFFF9C, 32'h0, 0, 0);
        issue("st_half", 1, 2'b01, 0, 32'h82, 32'h12348001, 32'h0, 0, 0);
        issue("ld_merged", 0, 2'b00, 0, 32'h80, 32'h0, 32'h80019C00, 0, 0);
        issue("ld_sbyte", 0, 2'b10, 1, 32'h81, 32'h0, 32'hFFFFFF9C, 0, 0);
        issue("ld_ubyte", 0, 2'b10, 0, 32'h81, 32'h0, 32'h0000009C, 0, 0);
        issue("ld_shalf", 0, 2'b01, 1, 32'h82, 32'h0, 32'hFFFF8001, 0, 0);
        issue("ld_uhalf", 0, 2'b01, 0, 32'h80, 32'h0, 32'h00009C00, 0, 0);
        issue("ld_sbyte0", 0, 2'b10, 1, 32'h80, 32'h0, 32'h00000000, 0, 0);

        issue("b2b0", 0, 2'b00, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);
        issue("b2b1", 0, 2'b00, 0, 32'h80, 32'h0, 32'h80019C00, 0, 2);
        issue("b2b2", 0, 2'b10, 0, 32'h81, 32'h0, 32'h0000009C, 0, 2);
        issue("b2b3", 0, 2'b01, 0, 32'h82, 32'h0, 32'h00008001, 0, 3);

        issue("st_old", 1, 2'b00, 0, 32'h10, 32'hAAAAAAAA, 32'h0, 0, 0);
        issue("ld_old", 0, 2'b00, 0, 32'h10, 32'h0, 32'hAAAAAAAA, 0, 0);
        @(negedge Clk);
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqSize  = 2'b00;
        ReqAddr  = 32'h10;
        ReqWData = 32'h12345678;
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        Reset = 1'b0;
        #1;
        check("abort_valid", 32'(RespValid), 32'd0);
        check("abort_rdata", RespRData, 32'd0);
        check("abort_err", 32'(RespErr), 32'd0);
        check("abort_ready", 32'(ReqReady), 32'd1);
        @(negedge Clk);
        Reset = 1'b1;
        issue("ld_after_abort", 0, 2'b00, 0, 32'h10, 32'h0, 32'hAAAAAAAA, 0, 0);

        issue("st_wrap", 1, 2'b00, 0, 32'h1004, 32'h55667788, 32'h0, 0, 0);
        issue("ld_wrap", 0, 2'b00, 0, 32'h0004, 32'h0, 32'h55667788, 0, 0);

        issue("st_mis_base", 1, 2'b00, 0, 32'h20, 32'h11223344, 32'h0, 0, 0);
        issue("ld_half_mis", 0, 2'b01, 0, 32'h23, 32'h0, TRAP ? 32'h0 : 32'h00001122, TRAP, 0);
        issue("st_half_mis", 1, 2'b01, 0, 32'h21, 32'h0000BEEF, 32'h0, TRAP, 0);
        issue("ld_after_mis", 0, 2'b00, 0, 32'h20, 32'h0,
              TRAP ? 32'h11223344 : 32'h1122BEEF, 0, 0);
        issue("ld_word_mis", 0, 2'b00, 0, 32'h22, 32'h0, TRAP ? 32'h0 : 32'h1122BEEF, TRAP, 0);
        issue("ld_byte_hi", 0, 2'b10, 1, 32'h23, 32'h0, 32'h00000011, 0, 0);
        issue("ld_byte_lo", 0, 2'b10, 1, 32'h20, 32'h0,
              TRAP ? 32'h00000044 : 32'hFFFFFFEF, 0, 0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
